// File: rtl/layer_out_serializer.sv
// layer_out_serializer
//   Captures one activation per neuron of a source layer (each neuron raises
//   its bit of in_valid for one cycle alongside its in_data slice). Once every
//   neuron has reported, the captured frame is replayed in neuron-index order
//   on a valid/ready stream feeding the next layer.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : [numNeurons]          per-neuron outvalid pulses
//   in_data    : [numNeurons*inWidth]  neuron i at [i*inWidth +: inWidth]
//   out_data   : [dataWidth]           zero-extended activation of neuron idx
//   out_valid  : word on out_data is valid (high throughout SEND)
//   out_ready  : downstream accepts the current word
//   out_last   : current word belongs to neuron numNeurons-1
//   busy       : block is replaying a frame
//   overflow   : sticky; duplicate capture or input arriving during replay
//   frame_cnt  : [cntWidth] completed frames, wraps
module layer_out_serializer #(
    parameter int unsigned numNeurons = 34,
    parameter int unsigned inWidth    = 8,
    parameter int unsigned dataWidth  = 16,
    parameter int unsigned cntWidth   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons-1:0]           in_valid,
    input  logic [numNeurons*inWidth-1:0]   in_data,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            overflow,
    output logic [cntWidth-1:0]             frame_cnt
);

    localparam int unsigned IdxWidth = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(numNeurons - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [numNeurons-1:0]   mask_q, mask_d;
    logic [IdxWidth-1:0]     idx_q, idx_d;
    logic                    overflow_q, overflow_d;
    logic [cntWidth-1:0]     frame_cnt_q, frame_cnt_d;
    logic [inWidth-1:0]      buffer_q [numNeurons];
    logic [inWidth-1:0]      buffer_d [numNeurons];

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        buffer_d    = buffer_q;

        case (state_q)
            COLLECT: begin
                for (int unsigned i = 0; i < numNeurons; i++) begin
                    if (in_valid[i]) begin
                        buffer_d[i] = in_data[i*inWidth +: inWidth];
                    end
                end
                mask_d = mask_q | in_valid;
                if (|(mask_q & in_valid)) begin
                    overflow_d = 1'b1;
                end
                // Completion includes bits arriving on this very edge, so the
                // last capture and the switch to SEND happen together.
                if (&(mask_q | in_valid)) begin
                    state_d = SEND;
                    mask_d  = '0;
                    idx_d   = '0;
                end
            end
            SEND: begin
                // Inputs during replay are discarded, never buffered.
                if (|in_valid) begin
                    overflow_d = 1'b1;
                end
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d     = COLLECT;
                        idx_d       = '0;
                        frame_cnt_d = frame_cnt_q + cntWidth'(1);
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            idx_q       <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Buffer contents are don't-care after reset; mask tracks validity.
    always_ff @(posedge clk) begin
        buffer_q <= buffer_d;
    end

    always_comb begin
        busy      = (state_q == SEND);
        out_valid = busy;
        out_last  = busy && (idx_q == LastIdx);
        out_data  = busy ? dataWidth'(buffer_q[idx_q]) : '0;
        overflow  = overflow_q;
        frame_cnt = frame_cnt_q;
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with 4 neurons, 8-bit activations,
// 16-bit output words and a 2-bit frame counter.
module tb_layer_out_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overflow;
    logic [1:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    layer_out_serializer #(
        .numNeurons(4),
        .inWidth(8),
        .dataWidth(16),
        .cntWidth(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .overflow(overflow),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of in_valid pulses, then inputs return idle.
    task automatic capture(input logic [3:0] v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        tick();
        in_valid = '0;
    endtask

    // Expects word 0 visible now; drains the frame with out_ready=1.
    task automatic expect_frame(input string tag, input logic [31:0] words);
        logic [31:0] w;
        w = words;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), out_valid, 1);
            check($sformatf("%s data[%0d]", tag, i), out_data, {24'h0, w[i*8 +: 8]});
            check($sformatf("%s last[%0d]", tag, i), out_last, (i == 3) ? 1 : 0);
            tick();
        end
        check({tag, " valid_after"}, out_valid, 0);
        check({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        logic [1:0] exp_bp_idx [7];
        logic       bp_ready [7];
        logic [31:0] bp_words;

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst out_valid", out_valid, 0);
        check("rst out_last", out_last, 0);
        check("rst busy", busy, 0);
        check("rst overflow", overflow, 0);
        check("rst out_data", out_data, 0);
        check("rst frame_cnt", frame_cnt, 0);

        // Simultaneous capture
        capture(4'b1111, 32'h44332211);
        expect_frame("simul", 32'h44332211);
        check("simul frame_cnt", frame_cnt, 1);

        // Staggered capture: order 2, 0, 3, 1
        capture(4'b0100, 32'h00A20000);
        check("stag valid after b2", out_valid, 0);
        capture(4'b0001, 32'h000000A0);
        check("stag valid after b0", out_valid, 0);
        capture(4'b1000, 32'hA3000000);
        check("stag valid after b3", out_valid, 0);
        capture(4'b0010, 32'h0000A100);
        expect_frame("stag", 32'hA3A2A1A0);
        check("stag frame_cnt", frame_cnt, 2);
        check("stag overflow", overflow, 0);

        // Backpressure: out_ready 0,0,1,0,1,1,1
        bp_ready   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_bp_idx = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        bp_words   = 32'hB4B3B2B1;
        out_ready  = 1'b0;
        capture(4'b1111, bp_words);
        for (int c = 0; c < 7; c++) begin
            out_ready = bp_ready[c];
            check($sformatf("bp valid[%0d]", c), out_valid, 1);
            check($sformatf("bp data[%0d]", c), out_data, {24'h0, bp_words[exp_bp_idx[c]*8 +: 8]});
            check($sformatf("bp last[%0d]", c), out_last, (exp_bp_idx[c] == 2'd3) ? 1 : 0);
            tick();
        end
        check("bp busy_after", busy, 0);
        check("bp frame_cnt", frame_cnt, 3);
        out_ready = 1'b1;

        // Overflow (a): in_valid[0] pulses during SEND
        capture(4'b1111, 32'hC4C3C2C1);
        check("ovfA word0", out_data, 16'h00C1);
        in_valid = 4'b0001;
        in_data  = 32'h000000EE;
        tick();
        in_valid = '0;
        check("ovfA overflow", overflow, 1);
        check("ovfA word1", out_data, 16'h00C2);
        tick();
        check("ovfA word2", out_data, 16'h00C3);
        tick();
        check("ovfA word3", out_data, 16'h00C4);
        check("ovfA last", out_last, 1);
        tick();
        check("ovfA busy_after", busy, 0);
        check("ovfA frame_cnt wrap", frame_cnt, 0);

        // Overflow (b): duplicate in_valid[1] during COLLECT
        check("ovfB overflow persists", overflow, 1);
        capture(4'b0010, 32'h00005100);
        capture(4'b0010, 32'h00005200);
        check("ovfB no early send", out_valid, 0);
        capture(4'b1101, 32'hD3D200D0);
        expect_frame("ovfB", 32'hD3D252D0);
        check("ovfB overflow", overflow, 1);
        check("ovfB frame_cnt", frame_cnt, 1);

        // Reset mid-frame
        capture(4'b0001, 32'h00000061);
        capture(4'b0010, 32'h00006200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst overflow", overflow, 0);
        check("mrst frame_cnt", frame_cnt, 0);
        check("mrst out_valid", out_valid, 0);
        capture(4'b0100, 32'h00730000);
        capture(4'b1000, 32'h74000000);
        check("mrst no stale mask", out_valid, 0);
        capture(4'b0001, 32'h00000071);
        check("mrst still collecting", out_valid, 0);
        capture(4'b0010, 32'h00007200);
        expect_frame("mrst", 32'h74737271);
        check("mrst frame_cnt", frame_cnt, 1);

        // Frame counter wrap: continues 2, 3, 0, 1
        for (int f = 0; f < 4; f++) begin
            logic [31:0] w;
            w = {8'h14 + 8'(f), 8'h13 + 8'(f), 8'h12 + 8'(f), 8'h11 + 8'(f)};
            capture(4'b1111, w);
            expect_frame($sformatf("wrap%0d", f), w);
            check($sformatf("wrap%0d frame_cnt", f), frame_cnt, 32'((f + 2) % 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
